// File: rtl/pwd_lock_pkg.sv
// pwd_lock_pkg: shared state encoding, entry geometry and digit packing for the password lock.
package pwd_lock_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int DIGIT_W    = 2;
  localparam int NIBBLE_W   = 4;
  localparam int ENTRY_W    = NUM_DIGITS * NIBBLE_W;

  typedef enum logic [2:0] {
    LOCKED = 3'd0,
    ENTER  = 3'd1,
    CHECK  = 3'd2,
    OPEN   = 3'd3,
    SET    = 3'd4,
    ALARM  = 3'd5
  } state_t;

  // Each digit occupies the low bits of its own nibble, so entries read naturally in hex.
  function automatic logic [NIBBLE_W-1:0] pack_digit(input logic [DIGIT_W-1:0] d);
    return {{(NIBBLE_W-DIGIT_W){1'b0}}, d};
  endfunction

endpackage

// File: rtl/pwd_lock_if.sv
// pwd_lock_if: key/command inputs and status outputs between the front end and the lock controller.
interface pwd_lock_if;
  import pwd_lock_pkg::*;

  logic                 key_valid;
  logic [DIGIT_W-1:0]   key_code;
  logic                 lock_req;
  logic                 set_req;
  logic                 unlocked;
  logic                 alarm;
  logic [ENTRY_W-1:0]   entry_data;
  logic [2:0]           digit_cnt;
  logic [1:0]           fail_cnt;
  state_t               state;

  modport master (
    output key_valid, key_code, lock_req, set_req,
    input  unlocked, alarm, entry_data, digit_cnt, fail_cnt, state
  );

  modport slave (
    input  key_valid, key_code, lock_req, set_req,
    output unlocked, alarm, entry_data, digit_cnt, fail_cnt, state
  );

endinterface

// File: rtl/pwd_lock_timer.sv
// pwd_lock_timer: loadable down-counter that saturates at zero; a load wins over the decrement.
module pwd_lock_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_value,
  output logic [W-1:0] o_value,
  output logic         o_zero
);

  logic [W-1:0] r_value;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_value <= '0;
    else if (i_load)
      r_value <= i_value;
    else if (!o_zero)
      r_value <= r_value - W'(1);
  end

  assign o_value = r_value;
  assign o_zero  = (r_value == '0);

endmodule

// File: rtl/pwd_lock_ctrl.sv
// pwd_lock_ctrl: assembles 4-digit key entries, checks them against the stored password and
// sequences unlock, password change, failure lockout and timeouts.
module pwd_lock_ctrl
  import pwd_lock_pkg::*;
#(
  parameter logic [ENTRY_W-1:0] DEFAULT_PW    = 16'h0123,
  parameter int                 MAX_FAIL      = 3,
  parameter int                 ENTRY_TIMEOUT = 50_000_000,
  parameter int                 OPEN_CYCLES   = 250_000_000,
  parameter int                 ALARM_CYCLES  = 500_000_000
) (
  input  logic        clk,
  input  logic        rst,
  pwd_lock_if.slave   bus
);

  localparam int MAX_AB = (ENTRY_TIMEOUT > OPEN_CYCLES) ? ENTRY_TIMEOUT : OPEN_CYCLES;
  localparam int MAX_C  = (MAX_AB > ALARM_CYCLES) ? MAX_AB : ALARM_CYCLES;
  localparam int TW     = $clog2(MAX_C + 1);

  localparam logic [TW-1:0] ENTRY_TV = TW'(ENTRY_TIMEOUT);
  localparam logic [TW-1:0] OPEN_TV  = TW'(OPEN_CYCLES);
  localparam logic [TW-1:0] ALARM_TV = TW'(ALARM_CYCLES);

  state_t             r_state;
  logic [ENTRY_W-1:0] r_pw;
  logic [ENTRY_W-1:0] r_entry;
  logic [2:0]         r_cnt;
  logic [1:0]         r_fail;
  logic               r_unlocked;
  logic               r_alarm;

  logic [ENTRY_W-1:0] w_shift;
  logic               w_shift_en;
  logic               w_last_digit;
  logic               w_match;
  logic [1:0]         w_fail_next;
  logic               w_to_alarm;
  logic               w_expire;
  logic               w_load;
  logic [TW-1:0]      w_load_val;
  logic [TW-1:0]      w_tval;
  logic               w_tzero;

  pwd_lock_timer #(.W(TW)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load),
    .i_value (w_load_val),
    .o_value (w_tval),
    .o_zero  (w_tzero)
  );

  assign w_shift      = {r_entry[ENTRY_W-NIBBLE_W-1:0], pack_digit(bus.key_code)};
  assign w_last_digit = (r_cnt == 3'(NUM_DIGITS - 1));
  assign w_match      = (r_entry == r_pw);
  assign w_fail_next  = r_fail + 2'd1;
  assign w_to_alarm   = !w_match && (w_fail_next == 2'(MAX_FAIL));
  // Timeouts fire on the edge where the counter steps from 1 to 0, so a load of N gives N cycles.
  assign w_expire     = w_tzero || (w_tval == TW'(1));

  assign w_shift_en = bus.key_valid &&
                      ((r_state == LOCKED) || (r_state == ENTER) ||
                       ((r_state == SET) && !bus.lock_req));

  always_comb begin
    w_load     = w_shift_en || (r_state == CHECK) ||
                 ((r_state == OPEN) && bus.set_req && !bus.lock_req) ||
                 ((r_state == SET) && !bus.lock_req && !bus.key_valid && w_expire);
    w_load_val = (((r_state == CHECK) && w_match) || ((r_state == SET) && !w_shift_en)) ? OPEN_TV :
                 ((r_state == CHECK) && w_to_alarm) ? ALARM_TV : ENTRY_TV;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= LOCKED;
      r_pw       <= DEFAULT_PW;
      r_entry    <= '0;
      r_cnt      <= '0;
      r_fail     <= '0;
      r_unlocked <= 1'b0;
      r_alarm    <= 1'b0;
    end else begin
      case (r_state)
        LOCKED: begin
          if (bus.key_valid) begin
            r_entry <= w_shift;
            r_cnt   <= r_cnt + 3'd1;
            r_state <= ENTER;
          end
        end
        ENTER: begin
          if (bus.key_valid) begin
            r_entry <= w_shift;
            r_cnt   <= r_cnt + 3'd1;
            if (w_last_digit)
              r_state <= CHECK;
          end else if (w_expire) begin
            r_entry <= '0;
            r_cnt   <= '0;
            r_state <= LOCKED;
          end
        end
        CHECK: begin
          r_entry <= '0;
          r_cnt   <= '0;
          if (w_match) begin
            r_fail     <= '0;
            r_unlocked <= 1'b1;
            r_state    <= OPEN;
          end else begin
            r_fail  <= w_fail_next;
            r_alarm <= w_to_alarm;
            r_state <= w_to_alarm ? ALARM : LOCKED;
          end
        end
        OPEN: begin
          r_unlocked <= !(bus.lock_req || bus.set_req || w_expire);
          if (bus.lock_req)
            r_state <= LOCKED;
          else if (bus.set_req)
            r_state <= SET;
          else if (w_expire)
            r_state <= LOCKED;
        end
        SET: begin
          if (bus.lock_req) begin
            r_entry <= '0;
            r_cnt   <= '0;
            r_state <= LOCKED;
          end else if (bus.key_valid) begin
            r_entry <= w_last_digit ? '0 : w_shift;
            r_cnt   <= w_last_digit ? '0 : r_cnt + 3'd1;
            if (w_last_digit) begin
              r_pw    <= w_shift;
              r_state <= LOCKED;
            end
          end else if (w_expire) begin
            r_entry    <= '0;
            r_cnt      <= '0;
            r_unlocked <= 1'b1;
            r_state    <= OPEN;
          end
        end
        ALARM: begin
          if (w_expire) begin
            r_fail  <= '0;
            r_alarm <= 1'b0;
            r_state <= LOCKED;
          end
        end
        default: begin
          r_state    <= LOCKED;
          r_unlocked <= 1'b0;
          r_alarm    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.unlocked   = r_unlocked;
  assign bus.alarm      = r_alarm;
  assign bus.entry_data = r_entry;
  assign bus.digit_cnt  = r_cnt;
  assign bus.fail_cnt   = r_fail;
  assign bus.state      = r_state;

endmodule

// File: tb/tb_pwd_lock_ctrl.sv
// tb_pwd_lock_ctrl: directed scenarios for the password lock with a queue of expected outputs.
module tb_pwd_lock_ctrl;
  import pwd_lock_pkg::*;

  localparam int S_UNL = 0, S_ALM = 1, S_ENT = 2, S_CNT = 3, S_FAIL = 4, S_ST = 5;

  typedef struct {
    string       tag;
    int          sel;
    logic [15:0] val;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   n_total = 0;
  int   n_pass  = 0;
  exp_t sb[$];

  pwd_lock_if bus ();

  pwd_lock_ctrl #(
    .DEFAULT_PW    (16'h0123),
    .MAX_FAIL      (3),
    .ENTRY_TIMEOUT (16),
    .OPEN_CYCLES   (32),
    .ALARM_CYCLES  (20)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] obs(input int sel);
    case (sel)
      S_UNL:   return 16'(bus.unlocked);
      S_ALM:   return 16'(bus.alarm);
      S_ENT:   return bus.entry_data;
      S_CNT:   return 16'(bus.digit_cnt);
      S_FAIL:  return 16'(bus.fail_cnt);
      default: return 16'(bus.state);
    endcase
  endfunction

  task automatic push(input string tag, input int sel, input logic [15:0] val);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic check();
    exp_t        e;
    logic [15:0] o;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = obs(e.sel);
      n_total++;
      assert (o === e.val) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", e.tag, o, e.val);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic key(input logic [1:0] d);
    bus.key_valid = 1'b1;
    bus.key_code  = d;
    tick();
    bus.key_valid = 1'b0;
  endtask

  task automatic enter4(input logic [1:0] a, b, c, d);
    key(a); key(b); key(c); key(d);
  endtask

  task automatic push_reset(input string tag);
    push({tag, "_st"},   S_ST,   16'(LOCKED));
    push({tag, "_unl"},  S_UNL,  16'd0);
    push({tag, "_alm"},  S_ALM,  16'd0);
    push({tag, "_ent"},  S_ENT,  16'd0);
    push({tag, "_cnt"},  S_CNT,  16'd0);
    push({tag, "_fail"}, S_FAIL, 16'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.key_valid = 1'b0;
    bus.key_code  = 2'd0;
    bus.lock_req  = 1'b0;
    bus.set_req   = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    push_reset("rst");
    check();

    bus.lock_req = 1'b1;
    bus.set_req  = 1'b1;
    tick();
    bus.lock_req = 1'b0;
    bus.set_req  = 1'b0;
    push("locked_ignore", S_ST, 16'(LOCKED));
    check();

    enter4(0, 1, 2, 3);
    push("chk_st",  S_ST,  16'(CHECK));
    push("chk_ent", S_ENT, 16'h0123);
    push("chk_cnt", S_CNT, 16'd4);
    push("chk_unl", S_UNL, 16'd0);
    check();
    tick();
    push("open_unl",  S_UNL,  16'd1);
    push("open_st",   S_ST,   16'(OPEN));
    push("open_fail", S_FAIL, 16'd0);
    push("open_cnt",  S_CNT,  16'd0);
    check();
    repeat (31) tick();
    push("open_hold", S_UNL, 16'd1);
    check();
    tick();
    push("relock_unl", S_UNL, 16'd0);
    push("relock_st",  S_ST,  16'(LOCKED));
    check();

    for (int i = 1; i <= 3; i++) begin
      enter4(3, 3, 3, 3);
      tick();
      push("lockout_fail", S_FAIL, 16'(i));
      push("lockout_st",   S_ST,   (i == 3) ? 16'(ALARM) : 16'(LOCKED));
      push("lockout_alm",  S_ALM,  (i == 3) ? 16'd1 : 16'd0);
      check();
    end
    enter4(0, 1, 2, 3);
    push("alarm_keys_alm", S_ALM, 16'd1);
    push("alarm_keys_cnt", S_CNT, 16'd0);
    push("alarm_keys_unl", S_UNL, 16'd0);
    check();
    repeat (15) tick();
    push("alarm_hold", S_ALM, 16'd1);
    check();
    tick();
    push("alarm_end_alm",  S_ALM,  16'd0);
    push("alarm_end_st",   S_ST,   16'(LOCKED));
    push("alarm_end_fail", S_FAIL, 16'd0);
    check();

    key(1);
    key(2);
    push("to_st",  S_ST,  16'(ENTER));
    push("to_ent", S_ENT, 16'h0012);
    push("to_cnt", S_CNT, 16'd2);
    check();
    repeat (15) tick();
    push("to_hold_st",  S_ST,  16'(ENTER));
    push("to_hold_cnt", S_CNT, 16'd2);
    check();
    tick();
    push("to_end_st",   S_ST,   16'(LOCKED));
    push("to_end_ent",  S_ENT,  16'd0);
    push("to_end_cnt",  S_CNT,  16'd0);
    push("to_end_fail", S_FAIL, 16'd0);
    check();
    enter4(0, 1, 2, 3);
    tick();
    push("to_retry_unl", S_UNL, 16'd1);
    check();

    bus.set_req = 1'b1;
    tick();
    bus.set_req = 1'b0;
    push("set_st", S_ST, 16'(SET));
    check();
    enter4(2, 2, 1, 0);
    push("set_done_st",  S_ST,  16'(LOCKED));
    push("set_done_ent", S_ENT, 16'd0);
    push("set_done_cnt", S_CNT, 16'd0);
    push("set_done_unl", S_UNL, 16'd0);
    check();
    enter4(0, 1, 2, 3);
    tick();
    push("oldpw_unl",  S_UNL,  16'd0);
    push("oldpw_fail", S_FAIL, 16'd1);
    push("oldpw_st",   S_ST,   16'(LOCKED));
    check();
    enter4(2, 2, 1, 0);
    tick();
    push("newpw_unl",  S_UNL,  16'd1);
    push("newpw_fail", S_FAIL, 16'd0);
    check();

    bus.lock_req  = 1'b1;
    bus.set_req   = 1'b1;
    bus.key_valid = 1'b1;
    bus.key_code  = 2'd1;
    tick();
    bus.lock_req  = 1'b0;
    bus.set_req   = 1'b0;
    bus.key_valid = 1'b0;
    push("simul_st",  S_ST,  16'(LOCKED));
    push("simul_unl", S_UNL, 16'd0);
    push("simul_cnt", S_CNT, 16'd0);
    check();
    enter4(2, 2, 1, 0);
    tick();
    push("simul_pw_unl", S_UNL, 16'd1);
    check();

    bus.set_req = 1'b1;
    tick();
    bus.set_req = 1'b0;
    key(1);
    push("settmo_cnt", S_CNT, 16'd1);
    check();
    repeat (15) tick();
    push("settmo_hold", S_ST, 16'(SET));
    check();
    tick();
    push("settmo_st",  S_ST,  16'(OPEN));
    push("settmo_unl", S_UNL, 16'd1);
    push("settmo_cnt0", S_CNT, 16'd0);
    check();

    bus.set_req = 1'b1;
    tick();
    bus.set_req = 1'b0;
    key(1);
    key(1);
    push("midset_st",  S_ST,  16'(SET));
    push("midset_cnt", S_CNT, 16'd2);
    push("midset_ent", S_ENT, 16'h0011);
    check();
    rst = 1'b1;
    #1;
    push_reset("midrst");
    check();
    tick();
    rst = 1'b0;
    enter4(0, 1, 2, 3);
    tick();
    push("defpw_unl",  S_UNL,  16'd1);
    push("defpw_fail", S_FAIL, 16'd0);
    check();
    bus.lock_req = 1'b1;
    tick();
    bus.lock_req = 1'b0;
    enter4(2, 2, 1, 0);
    tick();
    push("gone_unl",  S_UNL,  16'd0);
    push("gone_fail", S_FAIL, 16'd1);
    check();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
